run_length_detector: RTL and testbench

Parametrised serial sequence detector that samples a 1-bit input stream and flags runs of identical bits or a fixed bit pattern. It is the generalised successor of the lab-level fixed-length one-hot detector: configurable run length, pattern width and detection mode, with a qualifying enable, synchronous clear and a detection-event counter. It sits between a debounced switch/serial source and status LEDs or downstream control logic.

---
 rtl/run_length_detector.sv | 103 ++++++++++
 tb/tb_run_length_detector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// run_length_detector
//   Serial detector for runs of identical bits or a fixed bit pattern on a
//   1-bit stream. All outputs are registered, so each one reflects the sample
//   taken at the previous qualifying edge.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous active-high reset, clears all state
//   clr      synchronous clear, wins over en
//   en       sample qualifier; w is consumed only when en=1
//   w        serial data bit
//   mode     00 run of ones, 01 run of zeros, 10 run of either, 11 pattern
//   z        detection flag for the last sample
//   run_cnt  length of the ongoing run, saturating at RUN_LEN
//   last_bit most recently sampled bit
//   hit_cnt  number of detecting samples, wraps modulo 2^HIT_W
module run_length_detector #(
    parameter int                RUN_LEN = 4,
    parameter int                CNT_W   = 3,
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
    parameter int                HIT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    output logic             z,
    output logic [CNT_W-1:0] run_cnt,
    output logic             last_bit,
    output logic [HIT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        MODE_ONES    = 2'b00,
        MODE_ZEROS   = 2'b01,
        MODE_EITHER  = 2'b10,
        MODE_PATTERN = 2'b11
    } mode_t;

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(RUN_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  sr, sr_next;
    logic [FILL_W-1:0] fill, fill_next;
    logic [CNT_W-1:0]  run_next;
    logic              det;
    mode_t             mode_sel;

    assign mode_sel = mode_t'(mode);
    assign sr_next  = {sr[PAT_W-2:0], w};

    always_comb begin
        run_next = run_cnt + CNT_W'(1);
        // run_cnt==0 means no sample since reset, so the stale last_bit of 0
        // must not extend a run of zeros.
        if (run_cnt == '0 || w != last_bit)
            run_next = CNT_W'(1);
        else if (run_cnt >= RUN_MAX)
            run_next = RUN_MAX;

        fill_next = (fill >= FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);

        det = 1'b0;
        case (mode_sel)
            MODE_ONES:    det = (run_next == RUN_MAX) &&  w;
            MODE_ZEROS:   det = (run_next == RUN_MAX) && !w;
            MODE_EITHER:  det = (run_next == RUN_MAX);
            MODE_PATTERN: det = (fill_next == FILL_MAX) && (sr_next == PATTERN);
            default:      det = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z        <= 1'b0;
            run_cnt  <= '0;
            last_bit <= 1'b0;
            hit_cnt  <= '0;
            sr       <= '0;
            fill     <= '0;
        end else if (clr) begin
            z        <= 1'b0;
            run_cnt  <= '0;
            last_bit <= 1'b0;
            hit_cnt  <= '0;
            sr       <= '0;
            fill     <= '0;
        end else if (en) begin
            z        <= det;
            run_cnt  <= run_next;
            last_bit <= w;
            sr       <= sr_next;
            fill     <= fill_next;
            if (det)
                hit_cnt <= hit_cnt + HIT_W'(1);
        end
    end

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;

    localparam int               RUN_LEN = 4;
    localparam int               CNT_W   = 3;
    localparam int               PAT_W   = 4;
    localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
    localparam int               HIT_W   = 8;

    logic             clk = 1'b0;
    logic             reset, clr, en, w;
    logic [1:0]       mode;
    logic             z, z2, last_bit, last_bit2;
    logic [CNT_W-1:0] run_cnt, run_cnt2;
    logic [HIT_W-1:0] hit_cnt;
    logic [1:0]       hit_cnt2;

    int vectors = 0;
    int errors  = 0;

    run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W), .PAT_W(PAT_W),
                          .PATTERN(PATTERN), .HIT_W(HIT_W)) dut (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .w(w), .mode(mode),
        .z(z), .run_cnt(run_cnt), .last_bit(last_bit), .hit_cnt(hit_cnt));

    // Narrow hit counter instance for the wrap check.
    run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W), .PAT_W(PAT_W),
                          .PATTERN(PATTERN), .HIT_W(2)) dut2 (
        .clk(clk), .reset(reset), .clr(clr), .en(en), .w(w), .mode(mode),
        .z(z2), .run_cnt(run_cnt2), .last_bit(last_bit2), .hit_cnt(hit_cnt2));

    always #5 clk = ~clk;

    // Reference model: full sample history since the last reset/clear.
    bit hist[$];
    int hits;
    bit z_m;

    function automatic int m_run();
        int r = 0;
        int i = hist.size() - 1;
        while (i >= 0 && r < RUN_LEN && hist[i] == hist[hist.size()-1]) begin
            r++;
            i--;
        end
        return r;
    endfunction

    function automatic void m_clear();
        hist.delete();
        hits = 0;
        z_m  = 1'b0;
    endfunction

    function automatic void m_sample(bit b, logic [1:0] md);
        logic [PAT_W-1:0] p = PATTERN;
        bit pat_ok;
        bit full;
        hist.push_back(b);
        if (hist.size() > 32) void'(hist.pop_front());
        full   = (m_run() == RUN_LEN);
        pat_ok = (hist.size() >= PAT_W);
        for (int k = 0; k < PAT_W && pat_ok; k++)
            if (hist[hist.size()-PAT_W+k] != p[PAT_W-1-k]) pat_ok = 1'b0;
        case (md)
            2'b00:   z_m = full &&  b;
            2'b01:   z_m = full && !b;
            2'b10:   z_m = full;
            default: z_m = pat_ok;
        endcase
        if (z_m) hits++;
    endfunction

    function automatic bit m_last();
        return (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
    endfunction

    task automatic step(input bit e, input bit c, input bit b);
        en = e; clr = c; w = b;
        @(posedge clk);
        if (reset || c) m_clear();
        else if (e)     m_sample(b, mode);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0; en = 1'b0; w = 1'b0; mode = 2'b00;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (z !== 1'b0)        begin errors++; $display("FAIL reset_z got %b want 0", z); end
        vectors++; if (run_cnt !== '0)    begin errors++; $display("FAIL reset_run got %0d want 0", run_cnt); end
        vectors++; if (last_bit !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last_bit); end
        vectors++; if (hit_cnt !== '0)    begin errors++; $display("FAIL reset_hit got %0d want 0", hit_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_mode00();
        bit seq[7]  = '{0,1,1,1,1,1,0};
        bit zexp[7] = '{0,0,0,0,1,1,0};
        mode = 2'b00;
        step(1, 1, 0);
        foreach (seq[i]) begin
            step(1, 0, seq[i]);
            vectors++; if (z !== zexp[i]) begin errors++; $display("FAIL m00_z[%0d] got %b want %b", i, z, zexp[i]); end
            vectors++; if (z !== z_m)     begin errors++; $display("FAIL m00_model_z[%0d] got %b want %b", i, z, z_m); end
        end
        vectors++; if (hit_cnt !== 8'd2) begin errors++; $display("FAIL m00_hit got %0d want 2", hit_cnt); end
        vectors++; if (run_cnt !== 3'd1) begin errors++; $display("FAIL m00_run got %0d want 1", run_cnt); end
    endtask

    task automatic test_mode01_hold();
        mode = 2'b01;
        step(1, 1, 0);
        step(1, 0, 1);
        repeat (4) step(1, 0, 0);
        vectors++; if (z !== 1'b1) begin errors++; $display("FAIL m01_z got %b want 1", z); end
        repeat (3) begin
            step(0, 0, 1'($urandom));
            vectors++; if (z !== 1'b1)       begin errors++; $display("FAIL hold_z got %b want 1", z); end
            vectors++; if (run_cnt !== 3'd4) begin errors++; $display("FAIL hold_run got %0d want 4", run_cnt); end
            vectors++; if (hit_cnt !== 8'd1) begin errors++; $display("FAIL hold_hit got %0d want 1", hit_cnt); end
        end
        step(1, 0, 0);
        vectors++; if (hit_cnt !== 8'd2) begin errors++; $display("FAIL m01_hit got %0d want 2", hit_cnt); end
    endtask

    task automatic test_pattern();
        bit seq[7]  = '{1,0,1,1,0,1,1};
        bit zexp[7] = '{0,0,0,1,0,0,1};
        mode = 2'b11;
        step(1, 1, 0);
        foreach (seq[i]) begin
            step(1, 0, seq[i]);
            vectors++; if (z !== zexp[i]) begin errors++; $display("FAIL pat_z[%0d] got %b want %b", i, z, zexp[i]); end
        end
        vectors++; if (hit_cnt !== 8'd2) begin errors++; $display("FAIL pat_hit got %0d want 2", hit_cnt); end
        step(1, 1, 0);
        step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
        vectors++; if (z !== 1'b0 || hit_cnt !== 8'd0) begin errors++; $display("FAIL pat_fill got z=%b hit=%0d want z=0 hit=0", z, hit_cnt); end
    endtask

    task automatic test_mode_switch();
        mode = 2'b10;
        step(1, 1, 0);
        repeat (4) step(1, 0, 1);
        vectors++; if (z !== 1'b1 || hit_cnt !== 8'd1) begin errors++; $display("FAIL sw_first got z=%b hit=%0d want z=1 hit=1", z, hit_cnt); end
        mode = 2'b00;
        step(1, 0, 1);
        vectors++; if (z !== 1'b1 || hit_cnt !== 8'd2) begin errors++; $display("FAIL sw_second got z=%b hit=%0d want z=1 hit=2", z, hit_cnt); end
        vectors++; if (run_cnt !== 3'd4) begin errors++; $display("FAIL sw_run got %0d want 4", run_cnt); end
    endtask

    task automatic test_async_reset();
        mode = 2'b00;
        step(1, 1, 0);
        repeat (3) step(1, 0, 1);
        reset = 1'b1;
        #1;
        vectors++; if ({z, run_cnt, last_bit, hit_cnt} !== '0) begin errors++; $display("FAIL areset got z=%b run=%0d last=%b hit=%0d want all 0", z, run_cnt, last_bit, hit_cnt); end
        vectors++; if (run_cnt2 !== '0) begin errors++; $display("FAIL areset_run2 got %0d want 0", run_cnt2); end
        m_clear();
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1);
            vectors++; if (z !== (i == 3)) begin errors++; $display("FAIL post_reset_z[%0d] got %b want %b", i, z, (i == 3)); end
        end
    endtask

    task automatic test_hit_wrap();
        logic [1:0] hexp[9] = '{0,0,0,1,2,3,0,1,2};
        mode = 2'b10;
        step(1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1);
            vectors++; if (hit_cnt2 !== hexp[i]) begin errors++; $display("FAIL wrap_hit[%0d] got %0d want %0d", i, hit_cnt2, hexp[i]); end
        end
        vectors++; if (hit_cnt !== 8'd6) begin errors++; $display("FAIL wrap_wide got %0d want 6", hit_cnt); end
        step(1, 1, 1);
        vectors++; if ({z, run_cnt, last_bit, hit_cnt} !== '0 || hit_cnt2 !== 2'd0) begin errors++; $display("FAIL clr_en got z=%b run=%0d last=%b hit=%0d want all 0", z, run_cnt, last_bit, hit_cnt); end
    endtask

    task automatic test_random();
        step(1, 1, 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));
            vectors++; if (z !== z_m)                  begin errors++; $display("FAIL rnd_z[%0d] got %b want %b", i, z, z_m); end
            vectors++; if (run_cnt !== CNT_W'(m_run())) begin errors++; $display("FAIL rnd_run[%0d] got %0d want %0d", i, run_cnt, m_run()); end
            vectors++; if (last_bit !== m_last())      begin errors++; $display("FAIL rnd_last[%0d] got %b want %b", i, last_bit, m_last()); end
            vectors++; if (hit_cnt !== HIT_W'(hits))   begin errors++; $display("FAIL rnd_hit[%0d] got %0d want %0d", i, hit_cnt, HIT_W'(hits)); end
            vectors++; if (hit_cnt2 !== 2'(hits))      begin errors++; $display("FAIL rnd_hit2[%0d] got %0d want %0d", i, hit_cnt2, 2'(hits)); end
        end
    endtask

    initial begin
        test_reset();
        test_mode00();
        test_mode01_hold();
        test_pattern();
        test_mode_switch();
        test_async_reset();
        test_hit_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
